// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Holds register-file geometry and the write request bundle.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// sync_fifo: small synchronous FIFO with wrapping pointers.
// Ports: clk, reset (sync, active high), push/wdata, pop/rdata
// (rdata shows the head combinationally), full, empty.
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells full from empty when the indices match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the RF write port between pipeline WB and a multi-cycle unit.
// Ports: clk, reset; wb_* (WB result, no backpressure); mc_* (MC result
// valid/ready into a FIFO); issue_* (MC op issue); dec_* / dec_stall
// (hazard check); wb_hold (WB bubble request); rf_* (RF write port).
// Optional: REGFILE_ARB_STARVE_GUARD_EN enables the starvation guard.
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]       wb_rd,
    input  logic                  mc_valid,
    output logic                  mc_ready,
    input  logic [REG_ADDR_W-1:0] mc_rd_addr,
    input  logic [XLEN-1:0]       mc_rd,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd_addr,
    input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
    input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
    input  logic [REG_ADDR_W-1:0] dec_rd_addr,
    output logic                  dec_stall,
    output logic                  wb_hold,
    output logic                  rf_write,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    output logic [XLEN-1:0]       rf_rd
);

    wb_req_t mc_req;
    wb_req_t head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    push;
    logic    pop;

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    assign mc_req = {mc_rd_addr, mc_rd};

    // mc_ready comes only from the FIFO pointers (no path from mc_valid).
    assign mc_ready = !fifo_full;
    assign push     = mc_valid && mc_ready;
    assign pop      = !wb_valid && !fifo_empty;

    sync_fifo #(
        .WIDTH($bits(wb_req_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (mc_req),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // WB always wins; pop already implies !wb_valid.
    always_comb begin
        rf_write   = 1'b0;
        rf_rd_addr = '0;
        rf_rd      = '0;
        unique case (1'b1)
            wb_valid: begin
                rf_write   = (wb_rd_addr != '0);
                rf_rd_addr = wb_rd_addr;
                rf_rd      = wb_rd;
            end
            pop: begin
                rf_write   = (head.addr != '0);
                rf_rd_addr = head.addr;
                rf_rd      = head.data;
            end
            default: ;
        endcase
    end

    // Clear first, then set, so a same-cycle issue keeps the bit.
    always_comb begin
        pend_d = pend_q;
        if (pop) pend_d[head.addr] = 1'b0;
        if (issue_valid && issue_rd_addr != '0)
            pend_d[issue_rd_addr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign dec_stall = pend_q[dec_rs1_addr] |
                       pend_q[dec_rs2_addr] |
                       pend_q[dec_rd_addr];

`ifdef REGFILE_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

    logic [CW-1:0] starve_cnt;
    logic          wb_hold_q;
    logic          blocked;

    assign blocked = !fifo_empty && wb_valid;
    assign wb_hold = wb_hold_q;

    // Counting the STARVE_MAX-th blocked cycle raises a one-cycle hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            wb_hold_q  <= 1'b0;
        end else begin
            wb_hold_q <= 1'b0;
            if (!blocked) begin
                starve_cnt <= '0;
            end else if (starve_cnt == CNT_LAST) begin
                starve_cnt <= '0;
                wb_hold_q  <= 1'b1;
            end else begin
                starve_cnt <= starve_cnt + CNT_ONE;
            end
        end
    end
`else
    logic unused_starve;
    assign unused_starve = ^STARVE_MAX;
    assign wb_hold       = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table plus scoreboard model.
// Covers stall, arbitration, backpressure, x0, set-wins, reset, guard.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd_addr;
    logic [31:0] mc_rd;
    logic        issue_valid;
    logic [4:0]  issue_rd_addr;
    logic [4:0]  dec_rs1_addr;
    logic [4:0]  dec_rs2_addr;
    logic [4:0]  dec_rd_addr;
    logic        dec_stall;
    logic        wb_hold;
    logic        rf_write;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_valid      (wb_valid),
        .wb_rd_addr    (wb_rd_addr),
        .wb_rd         (wb_rd),
        .mc_valid      (mc_valid),
        .mc_ready      (mc_ready),
        .mc_rd_addr    (mc_rd_addr),
        .mc_rd         (mc_rd),
        .issue_valid   (issue_valid),
        .issue_rd_addr (issue_rd_addr),
        .dec_rs1_addr  (dec_rs1_addr),
        .dec_rs2_addr  (dec_rs2_addr),
        .dec_rd_addr   (dec_rd_addr),
        .dec_stall     (dec_stall),
        .wb_hold       (wb_hold),
        .rf_write      (rf_write),
        .rf_rd_addr    (rf_rd_addr),
        .rf_rd         (rf_rd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        es;
        logic        er;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t mfifo[$];
    ent_t exp_q[$];
    logic [31:0] mpend;
    logic m_pop, m_push, m_rdy, m_stall;
    logic exp_hold;
    vec_t tbl[29];
    vec_t nullv;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic wv, input logic [4:0] wa, input logic [31:0] wd,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic iv, input logic [4:0] ia,
        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
        input logic ew, input logic [4:0] ea, input logic [31:0] ed,
        input logic es, input logic er);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd;
        v.mv = mv; v.ma = ma; v.md = md;
        v.iv = iv; v.ia = ia;
        v.r1 = r1; v.r2 = r2; v.rd = rd;
        v.ew = ew; v.ea = ea; v.ed = ed;
        v.es = es; v.er = er;
        return v;
    endfunction

    task automatic idle_in();
        wb_valid = 0; wb_rd_addr = 0; wb_rd = 0;
        mc_valid = 0; mc_rd_addr = 0; mc_rd = 0;
        issue_valid = 0; issue_rd_addr = 0;
        dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rd_addr = 0;
    endtask

    task automatic drive(input vec_t v);
        wb_valid = v.wv; wb_rd_addr = v.wa; wb_rd = v.wd;
        mc_valid = v.mv; mc_rd_addr = v.ma; mc_rd = v.md;
        issue_valid = v.iv; issue_rd_addr = v.ia;
        dec_rs1_addr = v.r1; dec_rs2_addr = v.r2; dec_rd_addr = v.rd;
    endtask

    task automatic model_reset();
        mfifo.delete();
        exp_q.delete();
        mpend = '0;
    endtask

    // Expected write for this cycle is queued as stimulus is applied.
    task automatic model_pre();
        m_pop  = 0;
        m_rdy  = (mfifo.size() < DEPTH);
        if (wb_valid) begin
            if (wb_rd_addr != 0) exp_q.push_back({wb_rd_addr, wb_rd});
        end else if (mfifo.size() > 0) begin
            m_pop = 1;
            if (mfifo[0].a != 0) exp_q.push_back(mfifo[0]);
        end
        m_push  = mc_valid && m_rdy;
        m_stall = mpend[dec_rs1_addr] | mpend[dec_rs2_addr] |
                  mpend[dec_rd_addr];
    endtask

    task automatic sb_check();
        ent_t e;
        chk("mc_ready", mc_ready, m_rdy);
        chk("dec_stall", dec_stall, m_stall);
        chk("wb_hold", wb_hold, exp_hold);
        chk("rf_write", rf_write, exp_q.size() != 0);
        if (rf_write && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rf_rd_addr", rf_rd_addr, e.a);
            chk("rf_rd", rf_rd, e.d);
        end
        exp_q.delete();
    endtask

    task automatic model_post();
        ent_t e;
        if (m_pop) begin
            e = mfifo.pop_front();
            mpend[e.a] = 1'b0;
        end
        if (m_push) mfifo.push_back({mc_rd_addr, mc_rd});
        if (issue_valid && issue_rd_addr != 0)
            mpend[issue_rd_addr] = 1'b1;
        mpend[0] = 1'b0;
    endtask

    task automatic row_check(input vec_t v, input int idx);
        chk($sformatf("row%0d_write", idx), rf_write, v.ew);
        if (v.ew) begin
            chk($sformatf("row%0d_addr", idx), rf_rd_addr, v.ea);
            chk($sformatf("row%0d_data", idx), rf_rd, v.ed);
        end
        chk($sformatf("row%0d_stall", idx), dec_stall, v.es);
        chk($sformatf("row%0d_ready", idx), mc_ready, v.er);
    endtask

    task automatic run_cycle(input bit has_row, input vec_t v,
                             input int idx);
        model_pre();
        @(negedge clk);
        sb_check();
        if (has_row) row_check(v, idx);
        model_post();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nullv    = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,0);
        exp_hold = 0;
        idle_in();
        model_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;

        for (int i = 0; i < 10; i++) run_cycle(0, nullv, 0);

        // issue x5, stall, MC result, release
        tbl[0]  = mk(0,0,0, 0,0,0, 1,5, 0,0,0, 0,0,0, 0,1);
        tbl[1]  = mk(0,0,0, 0,0,0, 0,0, 5,0,0, 0,0,0, 1,1);
        tbl[2]  = mk(0,0,0, 1,5,32'hDEADBEEF, 0,0, 5,0,0, 0,0,0, 1,1);
        tbl[3]  = mk(0,0,0, 0,0,0, 0,0, 5,0,0, 1,5,32'hDEADBEEF, 1,1);
        tbl[4]  = mk(0,0,0, 0,0,0, 0,0, 5,0,0, 0,0,0, 0,1);
        // WB and FIFO head in the same cycle
        tbl[5]  = mk(0,0,0, 1,7,32'h22, 0,0, 0,0,0, 0,0,0, 0,1);
        tbl[6]  = mk(1,3,32'h11, 0,0,0, 0,0, 0,0,0, 1,3,32'h11, 0,1);
        tbl[7]  = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,7,32'h22, 0,1);
        tbl[8]  = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,1);
        // backpressure with WB held
        tbl[9]  = mk(1,1,32'hA1, 1,8,32'h81, 0,0, 0,0,0, 1,1,32'hA1, 0,1);
        tbl[10] = mk(1,2,32'hA2, 1,9,32'h91, 0,0, 0,0,0, 1,2,32'hA2, 0,1);
        tbl[11] = mk(1,4,32'hA4, 1,10,32'hA0, 0,0, 0,0,0, 1,4,32'hA4, 0,0);
        tbl[12] = mk(0,0,0, 1,10,32'hA0, 0,0, 0,0,0, 1,8,32'h81, 0,0);
        tbl[13] = mk(0,0,0, 1,10,32'hA0, 0,0, 0,0,0, 1,9,32'h91, 0,1);
        tbl[14] = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,10,32'hA0, 0,1);
        tbl[15] = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,1);
        // x0 from MC and WB
        tbl[16] = mk(0,0,0, 1,0,32'h55, 1,0, 0,0,0, 0,0,0, 0,1);
        tbl[17] = mk(1,0,32'h66, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,1);
        tbl[18] = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,1);
        tbl[19] = mk(0,0,0, 1,11,32'hBB, 0,0, 0,0,0, 0,0,0, 0,1);
        tbl[20] = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,11,32'hBB, 0,1);
        // re-issue while popping: set wins; rs2 and rd hazards
        tbl[21] = mk(0,0,0, 0,0,0, 1,12, 0,0,0, 0,0,0, 0,1);
        tbl[22] = mk(0,0,0, 1,12,32'hC1, 0,0, 0,12,0, 0,0,0, 1,1);
        tbl[23] = mk(0,0,0, 0,0,0, 1,12, 0,12,0, 1,12,32'hC1, 1,1);
        tbl[24] = mk(0,0,0, 0,0,0, 0,0, 0,12,0, 0,0,0, 1,1);
        tbl[25] = mk(0,0,0, 0,0,0, 0,0, 0,0,12, 0,0,0, 1,1);
        tbl[26] = mk(0,0,0, 1,12,32'hC2, 0,0, 0,0,12, 0,0,0, 1,1);
        tbl[27] = mk(0,0,0, 0,0,0, 0,0, 0,0,12, 1,12,32'hC2, 1,1);
        tbl[28] = mk(0,0,0, 0,0,0, 0,0, 0,0,12, 0,0,0, 0,1);

        for (int i = 0; i < 29; i++) begin
            drive(tbl[i]);
            run_cycle(1, tbl[i], i);
        end

        // starvation: one entry queued, WB held high
        idle_in();
        wb_valid = 1; wb_rd_addr = 1; wb_rd = 32'h1;
        mc_valid = 1; mc_rd_addr = 14; mc_rd = 32'hE1;
        run_cycle(0, nullv, 0);
        mc_valid = 0;
        for (int i = 0; i < 12; i++) begin
            wb_valid = 1; wb_rd_addr = 2; wb_rd = 32'(i);
`ifdef REGFILE_ARB_STARVE_GUARD_EN
            exp_hold = (i == 8);
            if (i == 9) wb_valid = 0;
`endif
            run_cycle(0, nullv, 0);
        end
        exp_hold = 0;
        idle_in();
        run_cycle(0, nullv, 0);
        chk("starve_drained", mfifo.size(), 0);

        // reset mid-operation drops FIFO and pending bits
        idle_in();
        wb_valid = 1; wb_rd_addr = 1; wb_rd = 32'h1;
        mc_valid = 1; mc_rd_addr = 13; mc_rd = 32'hD;
        issue_valid = 1; issue_rd_addr = 13;
        run_cycle(0, nullv, 0);
        idle_in();
        wb_valid = 1; wb_rd_addr = 2; wb_rd = 32'h2;
        dec_rs1_addr = 13;
        run_cycle(0, nullv, 0);
        idle_in();
        dec_rs1_addr = 13;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        run_cycle(0, nullv, 0);
        idle_in();
        run_cycle(0, nullv, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
